// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: walks NDIGITS slots with a guard gap,
// double-buffers the displayed value at frame boundaries and optionally blanks leading zeros.
module sevenseg_scan_ctrl #(
    parameter int NDIGITS     = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD       = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [4*NDIGITS-1:0]   i_value,
    input  logic                   i_blank_lz,
    output logic [3:0]             o_data,
    output logic [NDIGITS-1:0]     o_digit_en,
    output logic                   o_frame_done,
    output logic                   o_pending
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [4*NDIGITS-1:0] r_active;
    logic [4*NDIGITS-1:0] r_pend_buf;
    logic                 r_pending;

    logic [3:0]           w_digit [NDIGITS];
    logic [NDIGITS-1:0]   w_blank;
    logic                 w_allz;
    logic                 w_guard_ok;
    logic                 w_slot_vis;
    logic                 w_frame_end;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        assign w_digit[g] = r_active[4*g +: 4];
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_blank = '0;
        w_allz  = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            w_allz     = w_allz && (w_digit[i] == 4'd0);
            w_blank[i] = w_allz;
        end
    end

    if (GUARD == 0) begin : g_no_guard
        assign w_guard_ok = !i_reset;
    end else begin : g_guard
        assign w_guard_ok = (r_cnt >= CNT_W'(GUARD));
    end

    assign w_slot_vis   = !(i_blank_lz && w_blank[r_idx]);
    assign w_frame_end  = (r_idx == LAST_IDX) && (r_cnt == LAST_CNT);

    assign o_data       = w_digit[r_idx];
    assign o_digit_en   = (w_guard_ok && w_slot_vis) ? (NDIGITS'(1) << r_idx) : '0;
    assign o_frame_done = w_frame_end;
    assign o_pending    = r_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_active   <= '0;
            r_pend_buf <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (r_cnt == LAST_CNT) begin
                r_cnt <= '0;
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Commit reads the old pending buffer, so a load on the boundary queues for the next frame.
            if (w_frame_end && r_pending) begin
                r_active <= r_pend_buf;
            end

            if (i_load) begin
                r_pend_buf <= i_value;
                r_pending  <= 1'b1;
            end else if (w_frame_end) begin
                r_pending  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexes an NDIGITS-digit BCD value onto a single shared sevenseg decoder and a common-segment multi-digit display. It sequences the decoder input `data` digit by digit and drives one-hot digit enables, with a guard (dead) interval between digits to prevent ghosting. New values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking is supported.

Parameters:
NDIGITS, 4, number of display digits (1..8).
REFRESH_DIV, 1000, clock cycles per digit slot (>= 2).
GUARD, 2, cycles at the start of each slot with all digit enables off (0 <= GUARD < REFRESH_DIV).

Ports:
clk  input  1  clock.
reset  input  1  synchronous active-high reset.
load  input  1  one-cycle strobe; captures `value` into the pending buffer.
value  input  4*NDIGITS  BCD digits; digit i is in bits [4i+3:4i], and digit 0 is least significant.
blank_lz  input  1  1 = enable leading-zero blanking.
data  output  4  BCD digit to the sevenseg decoder.
digit_en  output  NDIGITS  one-hot active-high digit enable.
frame_done  output  1  one-cycle pulse on the last cycle of each frame.
pending  output  1  1 = a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset (sampled on a clk edge while reset=1):
  - Outputs: data=0, digit_en=0, frame_done=0, pending=0.
  - Internal state: active buffer=0, pending buffer=0, slot index=0, slot counter=0.
  - Reset asserted mid-frame aborts the scan immediately and discards any pending value.
- Scan state, all registered:
  - slot index `idx` runs 0..NDIGITS-1; slot counter `cnt` runs 0..REFRESH_DIV-1.
  - `cnt` increments every cycle. When `cnt` wraps, `idx` increments; `idx` wraps NDIGITS-1 -> 0.
  - The first cycle after reset deasserts is idx=0, cnt=0.
  - Frame length is NDIGITS*REFRESH_DIV cycles.
- Outputs per cycle, as a function of the current (idx, cnt):
  - data = active digit[idx]. It is held constant for the whole slot, guard included.
  - digit_en = 0 while cnt < GUARD.
  - digit_en = (1 << idx) while cnt >= GUARD, unless digit idx is blanked, in which case it stays 0 for the whole slot.
  - frame_done = 1 only when idx=NDIGITS-1 and cnt=REFRESH_DIV-1.
- Leading-zero blanking:
  - Digit i is blanked when blank_lz=1, i != 0, and active digits NDIGITS-1 down to i are all 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - blank_lz is sampled live each cycle.
- Double buffering:
  - A load strobe writes `value` to the pending buffer and sets pending=1 on the next cycle.
  - A second load while pending=1 overwrites the pending buffer; the last write wins.
  - At the frame boundary (the frame_done cycle) with pending=1: active <= pending buffer, and pending clears next cycle. The next frame (idx=0, cnt=0) uses the new value.
  - A load in the frame_done cycle while pending=1: the old pending value commits to active, the new value goes into the pending buffer, and pending stays 1.
  - A load in the frame_done cycle while pending=0: the value goes to the pending buffer and commits at the following boundary. There is no same-cycle bypass.
- Non-BCD digits (>9) are passed to `data` unmodified. Their display is the decoder's concern.
- digit_en is never multi-hot. It is always 0 during the first GUARD cycles of any slot.

Test Plan:
- All tests use NDIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset then idle, no load:
  - -> data=0 in every slot.
  - -> digit_en is 0 in cycles 0-1 of each slot and 0001/0010/0100/1000 in cycles 2-7.
  - -> frame_done pulses every 32 cycles, first at cycle 31.
- load value=16'h1234 at cycle 5:
  - -> pending=1 from cycle 6 until after cycle 31.
  - -> data stays 0 in frame 0.
  - -> frame 1 shows data 4, 3, 2, 1 in slots 0-3.
  - -> pending=0 at cycle 32.
- blank_lz=1 with value 16'h0050 committed:
  - -> digit_en[3] and digit_en[2] stay 0 throughout.
  - -> digit_en[1] (data=5) and digit_en[0] (data=0) are asserted.
  - -> with value 16'h0000, only digit_en[0] asserts, with data=0.
- Back-to-back loads:
  - load 16'h1111 at cycle 10 and load 16'h2222 at cycle 12 -> frame 1 shows only 2s.
  - load 16'h3333 exactly at cycle 31 while pending -> frame 1 shows 2s, frame 2 shows 3s, and pending=1 throughout frame 1.
- Reset mid-frame at cycle 20 with pending=1:
  - -> the next cycle has digit_en=0, data=0, pending=0.
  - -> the scan restarts at idx 0, and frame_done occurs 32 cycles after reset release.
- Guard and one-hot check over 3 frames with random loads:
  - -> digit_en is never multi-hot.
  - -> digit_en is never nonzero when cnt < 2.
  - -> data never changes within a slot.
